edge_threshold_ctrl: RTL and testbench

//  Frame-synchronous threshold scheduler for the Sobel edge stage. Counts edge pixels per frame
//  and updates the magnitude-squared threshold only during vertical sync (frame-coherent).

---
 rtl/edge_threshold_ctrl.sv | 154 +++++++++++++++
 tb/tb_edge_threshold_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_threshold_ctrl.sv
// Frame-synchronous edge-threshold scheduler: counts qualified edge pixels per frame and
// re-evaluates the Sobel threshold once per frame. Optional stats counter: EDGE_THR_STATS_EN.
module edge_threshold_ctrl #(
  parameter int unsigned THR_WIDTH    = 33,
  parameter int unsigned CNT_WIDTH    = 19,
  parameter int unsigned THR_INIT     = 12800,
  parameter int unsigned THR_STEP     = 500,
  parameter int unsigned THR_MIN      = 100,
  parameter int unsigned THR_MAX      = 200000,
  parameter int unsigned TARGET_SCALE = 64,
  parameter int unsigned HYST         = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vs_ni,
  input  logic                 blank_ni,
  input  logic                 edge_i,
  input  logic [9:0]           sw_i,
  output logic [THR_WIDTH-1:0] threshold_o,
  output logic [CNT_WIDTH-1:0] edge_count_o,
  output logic                 update_o,
  output logic                 auto_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int unsigned CmpW  = CNT_WIDTH + 10;
  localparam int unsigned ThrW1 = THR_WIDTH + 1;

  typedef enum logic [1:0] {StWait, StCount, StUpdate} state_e;

  state_e                 state_q, state_d;
  logic                   vs_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
  logic [THR_WIDTH-1:0]   thr_q, thr_d;
  logic                   upd_q, upd_d;
  logic                   auto_q, auto_d;

  logic                   fs;
  logic                   inc;
  logic [CNT_WIDTH-1:0]   cnt_sum;
  logic [CmpW-1:0]        tgt, hyst_w, cnt_ext;
  logic                   go_up, go_dn;
  logic [ThrW1-1:0]       thr_ext, thr_up, thr_sub;
  logic [THR_WIDTH-1:0]   thr_inc, thr_dec, thr_auto, thr_man;
  logic [15:0]            man_prod;

  assign fs  = vs_q & ~vs_ni;
  assign inc = edge_i & blank_ni;

  // Saturating per-pixel accumulate
  assign cnt_sum = (inc && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  // Target compare is done wide enough that T+HYST cannot wrap
  assign tgt     = CmpW'(sw_i[8:0]) * CmpW'(TARGET_SCALE);
  assign hyst_w  = CmpW'(HYST);
  assign cnt_ext = CmpW'(edge_cnt_q);
  assign go_up   = cnt_ext > (tgt + hyst_w);
  assign go_dn   = (tgt >= hyst_w) && (cnt_ext < (tgt - hyst_w));

  assign thr_ext = {1'b0, thr_q};
  assign thr_up  = thr_ext + ThrW1'(THR_STEP);
  assign thr_sub = thr_ext - ThrW1'(THR_STEP);
  assign thr_inc = (thr_up > ThrW1'(THR_MAX)) ? THR_WIDTH'(THR_MAX) : thr_up[THR_WIDTH-1:0];
  // Below STEP+MIN the subtraction would land under the floor (or underflow): clamp
  assign thr_dec = (thr_ext >= ThrW1'(THR_STEP + THR_MIN)) ? thr_sub[THR_WIDTH-1:0]
                                                           : THR_WIDTH'(THR_MIN);

  always_comb begin
    thr_auto = thr_q;
    if (go_up) begin
      thr_auto = thr_inc;
    end else if (go_dn) begin
      thr_auto = thr_dec;
    end
  end

  assign man_prod = 16'(sw_i[8:0]) * 16'd100;
  assign thr_man  = THR_WIDTH'(man_prod);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    thr_d      = thr_q;
    upd_d      = 1'b0;
    auto_d     = auto_q;
    unique case (state_q)
      StWait: begin
        cnt_d = '0;
        if (fs) state_d = StCount;
      end
      StCount: begin
        cnt_d = cnt_sum;
        if (fs) begin
          edge_cnt_d = cnt_sum;
          cnt_d      = '0;
          state_d    = StUpdate;
        end
      end
      StUpdate: begin
        // This pixel already belongs to the new frame
        cnt_d   = cnt_sum;
        thr_d   = sw_i[9] ? thr_auto : thr_man;
        upd_d   = 1'b1;
        auto_d  = sw_i[9];
        state_d = StCount;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StWait;
      vs_q       <= 1'b1;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      thr_q      <= THR_WIDTH'(THR_INIT);
      upd_q      <= 1'b0;
      auto_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_ni;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      thr_q      <= thr_d;
      upd_q      <= upd_d;
      auto_q     <= auto_d;
    end
  end

`ifdef EDGE_THR_STATS_EN
  logic [15:0] frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (upd_d) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_q;
`else
  assign frame_cnt_o = 16'd0;
`endif

  assign threshold_o  = thr_q;
  assign edge_count_o = edge_cnt_q;
  assign update_o     = upd_q;
  assign auto_o       = auto_q;

endmodule

// File: tb/tb_edge_threshold_ctrl.sv
// Self-checking bench for edge_threshold_ctrl: directed frame sequences plus random frames,
// compared every cycle against a frame-level integer model.
module tb_edge_threshold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs_ni, blank_ni, edge_i;
  logic [9:0]  sw;
  logic [32:0] threshold_o;
  logic [18:0] edge_count_o;
  logic        update_o, auto_o;
  logic [15:0] frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  longint m_thr, m_ec, m_cnt, m_frames;
  bit     m_vs_prev, m_armed, m_pend, m_upd, m_auto;

  edge_threshold_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .vs_ni        (vs_ni),
    .blank_ni     (blank_ni),
    .edge_i       (edge_i),
    .sw_i         (sw),
    .threshold_o  (threshold_o),
    .edge_count_o (edge_count_o),
    .update_o     (update_o),
    .auto_o       (auto_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_frames();
`ifdef EDGE_THR_STATS_EN
    return m_frames % 65536;
`else
    return 0;
`endif
  endfunction

  function automatic longint new_thr(longint thr, longint cnt, logic [9:0] s);
    longint t;
    t = longint'(s[8:0]) * 64;
    if (!s[9]) return longint'(s[8:0]) * 100;
    if (cnt > t + 1024) return (thr + 500 > 200000) ? 200000 : thr + 500;
    if (t >= 1024 && cnt < t - 1024) return (thr - 500 < 100) ? 100 : thr - 500;
    return thr;
  endfunction

  task automatic model_reset();
    m_thr = 12800; m_ec = 0; m_cnt = 0; m_frames = 0;
    m_vs_prev = 1'b1; m_armed = 1'b0; m_pend = 1'b0; m_upd = 1'b0; m_auto = 1'b0;
  endtask

  task automatic check_all(input string where);
    chk({where, ":thr"},    64'(threshold_o),  64'(m_thr));
    chk({where, ":ec"},     64'(edge_count_o), 64'(m_ec));
    chk({where, ":upd"},    64'(update_o),     64'(m_upd));
    chk({where, ":auto"},   64'(auto_o),       64'(m_auto));
    chk({where, ":frames"}, 64'(frame_cnt_o),  64'(exp_frames()));
  endtask

  // One pixel clock with the given inputs; model advances on the edge, outputs checked after
  task automatic cyc(input bit vs, input bit blank, input bit edg);
    bit fs, inc;
    vs_ni = vs; blank_ni = blank; edge_i = edg;
    @(posedge clk);
    fs  = m_vs_prev & ~vs;
    inc = edg & blank;
    m_vs_prev = vs;
    m_upd = 1'b0;
    if (m_pend) begin
      m_thr  = new_thr(m_thr, m_ec, sw);
      m_upd  = 1'b1;
      m_auto = sw[9];
      m_frames++;
      m_pend = 1'b0;
    end
    if (fs && m_armed) begin
      m_ec   = (m_cnt + inc > 524287) ? 524287 : m_cnt + inc;
      m_cnt  = 0;
      m_pend = 1'b1;
    end else if (fs) begin
      m_armed = 1'b1;
      m_cnt   = 0;
    end else if (m_armed) begin
      m_cnt = (m_cnt + inc > 524287) ? 524287 : m_cnt + inc;
    end
    #1;
    check_all("cyc");
  endtask

  // vs_ni low for one pixel (frame start), then n pixels of active video
  task automatic frame(input int n, input int edge_pct, input int vis_pct, input bit fs_edge);
    cyc(1'b0, 1'b1, fs_edge);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, ($urandom_range(99) < vis_pct), ($urandom_range(99) < edge_pct));
    end
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic reset_mid();
    vs_ni = 1'b1; blank_ni = 1'b1; edge_i = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("rst_rel");
  endtask

  initial begin
    rst = 1'b1; vs_ni = 1'b1; blank_ni = 1'b1; edge_i = 1'b0; sw = 10'h005;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Manual level 5: first fs only arms, second produces threshold 500
    frame(50, 50, 90, 1'b0);
    chk("t1_no_upd_thr", 64'(threshold_o), 64'd12800);
    frame(50, 50, 90, 1'b0);
    chk("t1_thr", 64'(threshold_o), 64'd500);

    // Auto, T=512, 5000 edges per frame: one step up per frame
    reset_mid();
    sw = 10'h208;
    frame(5000, 100, 100, 1'b0);
    frame(5000, 100, 100, 1'b0);
    chk("t2_thr1", 64'(threshold_o), 64'd13300);
    chk("t2_ec", 64'(edge_count_o), 64'd5000);
    frame(20, 0, 100, 1'b0);
    chk("t2_thr2", 64'(threshold_o), 64'd13800);

    // Manual 600, then auto T=2048 with empty frames clamps at 100, T=512 holds
    sw = 10'h006;
    frame(20, 0, 100, 1'b0);
    chk("t3_man", 64'(threshold_o), 64'd600);
    sw = 10'h220;
    frame(20, 0, 100, 1'b0);
    chk("t3_dn", 64'(threshold_o), 64'd100);
    frame(20, 0, 100, 1'b0);
    chk("t3_clamp", 64'(threshold_o), 64'd100);
    sw = 10'h208;
    frame(20, 0, 100, 1'b0);
    chk("t3_hold", 64'(threshold_o), 64'd100);
    chk("t3_auto", 64'(auto_o), 64'd1);

    // Blanked edges are ignored; an edge on the fs pixel closes the old frame
    sw = 10'h005;
    frame(100, 100, 0, 1'b0);
    frame(10, 0, 100, 1'b0);
    chk("t4_blank", 64'(edge_count_o), 64'd0);
    frame(10, 0, 100, 1'b1);
    chk("t4_fs_edge", 64'(edge_count_o), 64'd1);

    // Reset mid-frame: next fs only re-arms
    frame(30, 50, 100, 1'b0);
    reset_mid();
    chk("t5_thr", 64'(threshold_o), 64'd12800);
    frame(20, 50, 90, 1'b0);
    chk("t5_suppr", 64'(threshold_o), 64'd12800);
    frame(20, 50, 90, 1'b0);
    frame(20, 50, 90, 1'b0);
    frame(20, 50, 90, 1'b0);
`ifdef EDGE_THR_STATS_EN
    chk("t6_frames", 64'(frame_cnt_o), 64'd3);
`else
    chk("t6_frames", 64'(frame_cnt_o), 64'd0);
`endif

    // Back-to-back frame starts
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
    end

    // Random frames, mode and target, with sw changing mid-frame
    for (int f = 0; f < 40; f++) begin
      sw = 10'($urandom);
      cyc(1'b0, 1'b1, 1'($urandom));
      for (int i = 0; i < int'($urandom_range(400, 1)); i++) begin
        if (i == 3) sw = 10'($urandom);
        cyc(1'b1, ($urandom_range(99) < 80), ($urandom_range(99) < 60));
      end
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
